// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between core load/store and a DMA burst engine
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   core_req/we/addr/wdata         core single-cycle access request
//   core_gnt, core_rdata           combinational grant and load data
//   dma_start/dir/base/len         burst launch (sampled in IDLE only)
//   dma_abort                      terminate the running burst
//   dma_valid, dma_wdata           stream beat offer / write data
//   dma_ready, dma_rdata           beat executed this cycle, read-beat data
//   dma_busy, dma_done             burst running, one-cycle completion pulse
//   mem_addr/read/write/wdata      memory pins
//   mem_rdata                      memory combinational read data
module dmem_arbiter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdata,
    output logic          core_gnt,
    output logic [7:0]    core_rdata,
    input  logic          dma_start,
    input  logic          dma_dir,
    input  logic [AW-1:0] dma_base,
    input  logic [AW-1:0] dma_len,
    input  logic          dma_abort,
    input  logic          dma_valid,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ready,
    output logic [7:0]    dma_rdata,
    output logic          dma_busy,
    output logic          dma_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [AW:0]   beatCnt;
    logic [AW-1:0] baseQ;
    logic [AW-1:0] lenQ;
    logic          dirQ;
    logic          prio;

    logic          dmaWant;
    logic          contested;
    logic          coreGnt;
    logic          dmaGnt;
    logic [AW:0]   lastCnt;
    logic [AW-1:0] dmaAddr;

    // A latched length of 0 stands for a full 2**AW-beat sweep.
    assign lastCnt = (lenQ == '0) ? {1'b0, {AW{1'b1}}} : ({1'b0, lenQ} - CNT_ONE);

    // An abort in the same cycle as a beat suppresses the beat.
    assign dmaWant   = (state == RUN) && dma_valid && !dma_abort;
    assign contested = core_req && dmaWant;

    // Grants are gated by rst_n so they drop the instant reset is asserted,
    // even though core_req is a raw input.
    assign coreGnt = rst_n && core_req && (!dmaWant || !prio);
    assign dmaGnt  = rst_n && dmaWant && (!core_req || prio);

    // Address wraps modulo 2**AW by truncation.
    assign dmaAddr = baseQ + beatCnt[AW-1:0];

    assign core_gnt  = coreGnt;
    assign dma_ready = dmaGnt;
    assign dma_busy  = (state == RUN);
    assign dma_done  = (state == DONE);

    always_comb begin
        mem_addr   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 8'h00;
        core_rdata = 8'h00;
        dma_rdata  = 8'h00;
        if (coreGnt) begin
            mem_addr   = core_addr;
            mem_read   = !core_we;
            mem_write  = core_we;
            mem_wdata  = core_wdata;
            core_rdata = core_we ? 8'h00 : mem_rdata;
        end else if (dmaGnt) begin
            mem_addr  = dmaAddr;
            mem_read  = !dirQ;
            mem_write = dirQ;
            mem_wdata = dma_wdata;
            dma_rdata = dirQ ? 8'h00 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beatCnt <= '0;
            baseQ   <= '0;
            lenQ    <= '0;
            dirQ    <= 1'b0;
            prio    <= 1'b0;
        end else begin
            // Only contested cycles hand priority to the other side.
            if (contested) begin
                prio <= !prio;
            end
            case (state)
                IDLE: begin
                    if (dma_start) begin
                        baseQ   <= dma_base;
                        lenQ    <= dma_len;
                        dirQ    <= dma_dir;
                        beatCnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (dma_abort) begin
                        state <= IDLE;
                    end else if (dmaGnt) begin
                        beatCnt <= beatCnt + CNT_ONE;
                        if (beatCnt == lastCnt) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
